// File: rtl/anita4_trig_pkg.sv
// Shared types and constants for the ANITA4 single-pol trigger latch sequencer.
package anita4_trig_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StHoldoff,
        StRecover
    } chan_state_e;

    localparam int unsigned HoldoffW  = 8;
    localparam int unsigned DefClrLen = 2;
    localparam int unsigned DefScalW  = 16;

endpackage

// File: rtl/anita4_single_chan_fsm.sv
// One single-pol channel: hit acceptance, latch clear/holdoff/recover sequencing,
// mask handling and a saturating hit scaler.
module anita4_single_chan_fsm
    import anita4_trig_pkg::*;
#(
    parameter int unsigned CLR_LEN = DefClrLen,
    parameter int unsigned SCAL_W  = DefScalW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync,
    input  logic                mask,
    input  logic [HoldoffW-1:0] holdoff,
    input  logic                scal_latch,
    output logic                latch_clr,
    output logic                trig,
    output logic                busy,
    output logic [SCAL_W-1:0]   count
);

    localparam int unsigned ClrW = $clog2(CLR_LEN + 1);
    localparam int unsigned CntW = (ClrW > HoldoffW) ? ClrW : HoldoffW;
    localparam logic [CntW-1:0]   ClrLoad = CntW'(CLR_LEN - 1);
    localparam logic [SCAL_W-1:0] ScalMax = '1;

    chan_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SCAL_W-1:0] scal_q, scal_d;
    logic              mask_q;
    logic              latch_clr_q, latch_clr_d;
    logic              trig_q, trig_d;
    logic              busy_q, busy_d;
    logic              accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (mask) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    // First unmasked cycle: refill the sync pipeline before trusting it.
                    if (mask_q) begin
                        state_d = StRecover;
                        cnt_d   = '0;
                    end else if (sync) begin
                        accept  = 1'b1;
                        state_d = StClear;
                        cnt_d   = ClrLoad;
                    end
                end
                StClear: begin
                    if (cnt_q == '0) begin
                        if (holdoff == '0) begin
                            state_d = StRecover;
                            cnt_d   = '0;
                        end else begin
                            state_d = StHoldoff;
                            cnt_d   = CntW'(holdoff) - CntW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StHoldoff: begin
                    if (cnt_q == '0) begin
                        state_d = StRecover;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StRecover: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                default: begin
                    state_d = StRecover;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        trig_d      = accept;
        latch_clr_d = mask || (state_d == StClear) || (state_d == StHoldoff);
        busy_d      = mask || (state_d != StIdle);
        scal_d      = scal_q;
        // A hit coincident with the snapshot starts the new count.
        if (scal_latch) begin
            scal_d = accept ? SCAL_W'(1) : '0;
        end else if (accept && (scal_q != ScalMax)) begin
            scal_d = scal_q + SCAL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StRecover;
            // Two RECOVER cycles out of reset, so a hit is first accepted on the third edge.
            cnt_q       <= CntW'(1);
            scal_q      <= '0;
            mask_q      <= 1'b0;
            latch_clr_q <= 1'b1;
            trig_q      <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            scal_q      <= scal_d;
            mask_q      <= mask;
            latch_clr_q <= latch_clr_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
        end
    end

    assign latch_clr = latch_clr_q;
    assign trig      = trig_q;
    assign busy      = busy_q;
    assign count     = scal_q;

endmodule

// File: rtl/anita4_single_clear_ctrl.sv
// Per-channel trigger latch sequencer for ANITA4 single-pol channels, with
// snapshotted per-channel hit scalers.
module anita4_single_clear_ctrl
    import anita4_trig_pkg::*;
#(
    parameter int unsigned NCH     = 16,
    parameter int unsigned CLR_LEN = DefClrLen,
    parameter int unsigned SCAL_W  = DefScalW
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [NCH-1:0]        SYNC_IN,
    input  logic [NCH-1:0]        MASK,
    input  logic [HoldoffW-1:0]   HOLDOFF,
    input  logic                  SCAL_LATCH,
    output logic [NCH-1:0]        LATCH_CLR,
    output logic [NCH-1:0]        TRIG_OUT,
    output logic [NCH-1:0]        BUSY,
    output logic [NCH*SCAL_W-1:0] SCAL_OUT
);

    logic [NCH*SCAL_W-1:0] count;
    logic [NCH*SCAL_W-1:0] scal_out_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        anita4_single_chan_fsm #(
            .CLR_LEN (CLR_LEN),
            .SCAL_W  (SCAL_W)
        ) u_chan (
            .clk        (CLK),
            .rst        (CLR),
            .sync       (SYNC_IN[i]),
            .mask       (MASK[i]),
            .holdoff    (HOLDOFF),
            .scal_latch (SCAL_LATCH),
            .latch_clr  (LATCH_CLR[i]),
            .trig       (TRIG_OUT[i]),
            .busy       (BUSY[i]),
            .count      (count[i*SCAL_W +: SCAL_W])
        );
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            scal_out_q <= '0;
        end else if (SCAL_LATCH) begin
            scal_out_q <= count;
        end
    end

    assign SCAL_OUT = scal_out_q;

endmodule

// File: tb/tb_anita4_single_clear_ctrl.sv
// Self-checking bench: directed and random stimulus against a time-based reference
// model of hit acceptance, dead-time windows and scaler snapshots.
module tb_anita4_single_clear_ctrl;

    localparam int NCH     = 16;
    localparam int CLR_LEN = 2;
    localparam int SCAL_W  = 10;
    localparam int SMAX    = (1 << SCAL_W) - 1;

    logic                  CLK = 1'b0;
    logic                  CLR;
    logic [NCH-1:0]        SYNC_IN;
    logic [NCH-1:0]        MASK;
    logic [7:0]            HOLDOFF;
    logic                  SCAL_LATCH;
    logic [NCH-1:0]        LATCH_CLR;
    logic [NCH-1:0]        TRIG_OUT;
    logic [NCH-1:0]        BUSY;
    logic [NCH*SCAL_W-1:0] SCAL_OUT;

    anita4_single_clear_ctrl #(
        .NCH     (NCH),
        .CLR_LEN (CLR_LEN),
        .SCAL_W  (SCAL_W)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .SYNC_IN    (SYNC_IN),
        .MASK       (MASK),
        .HOLDOFF    (HOLDOFF),
        .SCAL_LATCH (SCAL_LATCH),
        .LATCH_CLR  (LATCH_CLR),
        .TRIG_OUT   (TRIG_OUT),
        .BUSY       (BUSY),
        .SCAL_OUT   (SCAL_OUT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: edge index e counts clock edges since reset release.
    int  e;
    bit  mprev  [NCH];
    bit  active [NCH];
    bit  known  [NCH];
    int  hit_e  [NCH];
    int  end_e  [NCH];
    int  ready  [NCH];
    int  cnt    [NCH];
    int  snap   [NCH];
    logic [NCH-1:0]        exp_clr, exp_trig, exp_busy;
    logic [NCH*SCAL_W-1:0] exp_scal;
    logic [SCAL_W-1:0]     field;

    task automatic model_reset();
        e = 0;
        for (int c = 0; c < NCH; c++) begin
            mprev[c]  = 1'b1;
            active[c] = 1'b0;
            known[c]  = 1'b0;
            ready[c]  = 0;
            cnt[c]    = 0;
            snap[c]   = 0;
        end
        exp_clr  = '1;
        exp_trig = '0;
        exp_busy = '1;
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit acc;
            acc = 1'b0;
            exp_trig[c] = 1'b0;
            if (MASK[c]) begin
                exp_clr[c] = 1'b1; exp_busy[c] = 1'b1;
                active[c] = 1'b0;  mprev[c] = 1'b1;
            end else if (mprev[c]) begin
                exp_clr[c] = 1'b0; exp_busy[c] = 1'b1;
                ready[c] = e + 2;  mprev[c] = 1'b0;
            end else if (active[c]) begin
                if (e == hit_e[c] + CLR_LEN) begin
                    end_e[c] = e + int'(HOLDOFF);
                    known[c] = 1'b1;
                end
                if (!known[c] || e < end_e[c]) begin
                    exp_clr[c] = 1'b1; exp_busy[c] = 1'b1;
                end else begin
                    exp_clr[c] = 1'b0; exp_busy[c] = 1'b1;
                    active[c] = 1'b0;  ready[c] = e + 2;
                end
            end else if (e >= ready[c] && SYNC_IN[c]) begin
                acc = 1'b1;
                active[c] = 1'b1; known[c] = 1'b0; hit_e[c] = e;
                exp_trig[c] = 1'b1; exp_clr[c] = 1'b1; exp_busy[c] = 1'b1;
            end else begin
                exp_clr[c]  = 1'b0;
                exp_busy[c] = (e + 1 < ready[c]);
            end
            if (SCAL_LATCH) begin
                snap[c] = cnt[c];
                cnt[c]  = acc ? 1 : 0;
            end else if (acc && cnt[c] < SMAX) begin
                cnt[c]++;
            end
        end
        e++;
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < NCH; c++) exp_scal[c*SCAL_W +: SCAL_W] = SCAL_W'(snap[c]);
        total++;
        assert (LATCH_CLR === exp_clr) else begin
            bad++;
            $error("FAIL %s latch_clr got=%h exp=%h", tag, LATCH_CLR, exp_clr);
        end
        total++;
        assert (TRIG_OUT === exp_trig) else begin
            bad++;
            $error("FAIL %s trig_out got=%h exp=%h", tag, TRIG_OUT, exp_trig);
        end
        total++;
        assert (BUSY === exp_busy) else begin
            bad++;
            $error("FAIL %s busy got=%h exp=%h", tag, BUSY, exp_busy);
        end
        total++;
        assert (SCAL_OUT === exp_scal) else begin
            bad++;
            $error("FAIL %s scal_out got=%h exp=%h", tag, SCAL_OUT, exp_scal);
        end
    endtask

    task automatic check_field(input string tag, input int ch, input int want);
        field = SCAL_OUT[ch*SCAL_W +: SCAL_W];
        total++;
        assert (field === SCAL_W'(want)) else begin
            bad++;
            $error("FAIL %s ch%0d scal got=%0d exp=%0d", tag, ch, field, want);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic reset_hold(input string tag);
        model_reset();
        repeat (2) begin
            @(posedge CLK);
            #1;
            check_all(tag);
        end
        CLR = 1'b0;
    endtask

    initial begin
        CLR = 1'b1; SYNC_IN = '0; MASK = '0; HOLDOFF = 8'd4; SCAL_LATCH = 1'b0;
        #1;
        reset_hold("reset");
        repeat (4) tick("release");

        // Single hit on channel 3.
        SYNC_IN = 16'h0008; tick("hit3");
        SYNC_IN = '0;       repeat (10) tick("hit3_seq");

        // Retrigger inside the dead time is discarded.
        SYNC_IN = 16'h0004; tick("dead_a");
        SYNC_IN = '0;       tick("dead_b");
        SYNC_IN = 16'h0004; tick("dead_c");
        SYNC_IN = '0;       repeat (10) tick("dead_d");

        // HOLDOFF=0 with SYNC_IN held: one hit every four cycles.
        HOLDOFF = 8'd0; SYNC_IN = 16'h0002; repeat (17) tick("ho0_hold");
        SYNC_IN = '0; HOLDOFF = 8'd4;       repeat (6) tick("ho0_end");

        // Mask mid-holdoff, then unmask with the latch still set.
        SYNC_IN = 16'h0020; tick("mask_hit");
        SYNC_IN = '0;       repeat (3) tick("mask_pre");
        MASK = 16'h0020;    repeat (6) tick("mask_on");
        MASK = '0; SYNC_IN = 16'h0020; repeat (4) tick("unmask");
        SYNC_IN = '0;       repeat (10) tick("unmask_end");

        // Scaler snapshot: three hits, then a fourth coincident with SCAL_LATCH.
        SCAL_LATCH = 1'b1; tick("scal_clr");
        SCAL_LATCH = 1'b0; tick("scal_clr2");
        for (int k = 0; k < 3; k++) begin
            SYNC_IN = 16'h0001; tick("scal_hit");
            SYNC_IN = '0;       repeat (7) tick("scal_gap");
        end
        SYNC_IN = 16'h0001; SCAL_LATCH = 1'b1; tick("scal_coinc");
        check_field("scal_snap3", 0, 3);
        SYNC_IN = '0; SCAL_LATCH = 1'b0; repeat (8) tick("scal_gap2");
        SCAL_LATCH = 1'b1; tick("scal_snap");
        check_field("scal_snap1", 0, 1);
        SCAL_LATCH = 1'b0; repeat (2) tick("scal_end");

        // All-channel burst.
        SYNC_IN = '1; tick("burst");
        SYNC_IN = '0; repeat (8) tick("burst_end");
        SCAL_LATCH = 1'b1; tick("burst_snap");
        SCAL_LATCH = 1'b0; tick("burst_snap2");

        // Random traffic, masks and holdoff changes.
        for (int k = 0; k < 600; k++) begin
            SYNC_IN = NCH'($urandom) & NCH'($urandom);
            if ($urandom_range(0, 19) == 0) MASK = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
            HOLDOFF    = 8'($urandom_range(0, 5));
            SCAL_LATCH = ($urandom_range(0, 30) == 0);
            tick("random");
        end
        SYNC_IN = '0; MASK = '0; SCAL_LATCH = 1'b0; HOLDOFF = 8'd3;
        repeat (12) tick("random_end");

        // Async reset mid-sequence.
        SYNC_IN = 16'h0410; tick("pre_clr");
        SYNC_IN = '0;       tick("pre_clr2");
        #2 CLR = 1'b1;
        #1;
        model_reset();
        check_all("clr_async");
        reset_hold("clr_hold");
        repeat (4) tick("clr_release");

        // Scaler saturation on channel 7.
        HOLDOFF = 8'd0; SYNC_IN = 16'h0080;
        repeat (4200) tick("sat");
        SYNC_IN = '0; SCAL_LATCH = 1'b1; tick("sat_snap");
        check_field("sat_value", 7, SMAX);
        SCAL_LATCH = 1'b0; repeat (4) tick("sat_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
